// File: rtl/tmp2_pkg.sv
// Shared types and constants for the Pmod TMP2 sequencer.
package tmp2_pkg;

  typedef enum logic [2:0] {
    WR_ISSUE,
    WR_ACK,
    WR_DONE,
    IDLE,
    RD_ISSUE,
    RD_ACK,
    RD_WAIT
  } state_t;

  localparam logic [1:0] TGT_CRIT = 2'd0;
  localparam logic [1:0] TGT_HYST = 2'd1;
  localparam logic [1:0] TGT_LOW  = 2'd2;
  localparam logic [1:0] TGT_HIGH = 2'd3;

  // Threshold write order, element 0 is written first: HIGH, LOW, CRIT, HYST.
  localparam logic [3:0][1:0] WR_ORDER = {TGT_HYST, TGT_CRIT, TGT_LOW, TGT_HIGH};

endpackage

// File: rtl/tmp2_timeout_ctr.sv
// Loadable down-counter with expiry flag; shared by the ack and valid waits.
module tmp2_timeout_ctr #(
  parameter int unsigned WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_run,
  output logic             o_expired
);

  logic [WIDTH-1:0] r_cnt;

  // Load wins over counting; count saturates at zero.
  always_ff @(posedge clk) begin
    if (rst)                        r_cnt <= '0;
    else if (i_load)                r_cnt <= i_value;
    else if (i_run && r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/tmp2_sequencer.sv
// Threshold-programming and polling sequencer for the Pmod TMP2 core.
// Optional min/max tracking is enabled by defining TMP2_MINMAX_EN.
module tmp2_sequencer
  import tmp2_pkg::*;
#(
  parameter int unsigned POLL_CYCLES = 100_000_000,
  parameter int unsigned ACK_TIMEOUT = 1_000_000,
  parameter logic [15:0] DEF_THIGH   = 16'h0C80,
  parameter logic [15:0] DEF_TLOW    = 16'h0500,
  parameter logic [15:0] DEF_TCRIT   = 16'h2000,
  parameter logic [15:0] DEF_THYST   = 16'h0005
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        thr_load,
  input  logic [15:0] thr_high,
  input  logic [15:0] thr_low,
  input  logic [15:0] thr_crit,
  input  logic [15:0] thr_hyst,
  input  logic        busy,
  input  logic        valid_o,
  input  logic [15:0] temperature_o,
  output logic        update,
  output logic        write_temperature,
  output logic [1:0]  write_temp_target,
  output logic [15:0] temperature_i,
  output logic [15:0] temp,
  output logic        temp_valid,
  output logic        over_high,
  output logic        under_low,
  output logic        over_crit,
`ifdef TMP2_MINMAX_EN
  input  logic        minmax_clr,
  output logic [15:0] temp_min,
  output logic [15:0] temp_max,
`endif
  output logic        err_timeout
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned PW = $clog2(POLL_CYCLES);
  localparam logic [TW-1:0] TO_LOAD   = TW'(ACK_TIMEOUT - 1);
  localparam logic [PW-1:0] POLL_LOAD = PW'(POLL_CYCLES - 1);

  state_t        r_state, w_next;
  logic [1:0]    r_idx;
  logic [PW-1:0] r_poll;
  logic          r_pend;
  logic [15:0]   r_thigh, r_tlow, r_tcrit, r_thyst;
  logic          r_wr_stb, r_rd_stb, r_err;
  logic [1:0]    r_tgt;
  logic [15:0]   r_wval, r_temp;
  logic          r_tvalid, r_over_high, r_under_low, r_over_crit;

  logic          w_wr_stb, w_rd_stb, w_to_load, w_to_run, w_to_exp, w_err_set;
  logic          w_poll_load, w_poll_dec, w_idx_clr, w_idx_inc, w_pend_take, w_restart;
  logic [1:0]    w_tgt;
  logic [15:0]   w_wval;

  tmp2_timeout_ctr #(.WIDTH(TW)) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_to_load),
    .i_value   (TO_LOAD),
    .i_run     (w_to_run),
    .o_expired (w_to_exp)
  );

  // Select the target and shadow value for the current write index.
  always_comb begin
    w_tgt = WR_ORDER[r_idx];
    case (w_tgt)
      TGT_HIGH: w_wval = r_thigh;
      TGT_LOW:  w_wval = r_tlow;
      TGT_CRIT: w_wval = r_tcrit;
      default:  w_wval = r_thyst;
    endcase
  end

  // Next-state and control decode.
  always_comb begin
    w_next      = r_state;
    w_wr_stb    = 1'b0;
    w_rd_stb    = 1'b0;
    w_to_load   = 1'b0;
    w_to_run    = 1'b0;
    w_err_set   = 1'b0;
    w_poll_load = 1'b0;
    w_poll_dec  = 1'b0;
    w_idx_clr   = 1'b0;
    w_idx_inc   = 1'b0;
    w_pend_take = 1'b0;
    w_restart   = r_pend | thr_load;
    case (r_state)
      WR_ISSUE: if (!busy) begin
        w_wr_stb = 1'b1; w_to_load = 1'b1; w_next = WR_ACK;
      end
      WR_ACK: begin
        if (busy) w_next = WR_DONE;
        else if (w_to_exp) begin w_err_set = 1'b1; w_next = WR_DONE; end
        else w_to_run = 1'b1;
      end
      // A pending reload restarts at index 0 once the current write is done.
      WR_DONE: if (!busy) begin
        if (w_restart) begin
          w_pend_take = 1'b1; w_idx_clr = 1'b1; w_next = WR_ISSUE;
        end else if (r_idx == 2'd3) begin
          w_poll_load = 1'b1; w_next = IDLE;
        end else begin
          w_idx_inc = 1'b1; w_next = WR_ISSUE;
        end
      end
      IDLE: begin
        if (w_restart) begin
          w_pend_take = 1'b1; w_idx_clr = 1'b1; w_next = WR_ISSUE;
        end else if (enable) begin
          if (r_poll == '0) w_next = RD_ISSUE;
          else w_poll_dec = 1'b1;
        end
      end
      RD_ISSUE: if (!busy) begin
        w_rd_stb = 1'b1; w_to_load = 1'b1; w_next = RD_ACK;
      end
      RD_ACK: begin
        if (busy) begin w_to_load = 1'b1; w_next = RD_WAIT; end
        else if (w_to_exp) begin w_err_set = 1'b1; w_to_load = 1'b1; w_next = RD_WAIT; end
        else w_to_run = 1'b1;
      end
      // The valid wait only counts once the core has dropped busy.
      RD_WAIT: begin
        if (valid_o) begin w_poll_load = 1'b1; w_next = IDLE; end
        else if (!busy) begin
          if (w_to_exp) begin w_err_set = 1'b1; w_poll_load = 1'b1; w_next = IDLE; end
          else w_to_run = 1'b1;
        end
      end
      default: w_next = WR_ISSUE;
    endcase
  end

  // Sequencer state, write index, poll counter and reload-pending flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= WR_ISSUE;
      r_idx   <= '0;
      r_poll  <= '0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_idx_clr)      r_idx <= '0;
      else if (w_idx_inc) r_idx <= r_idx + 1'b1;
      if (w_poll_load)     r_poll <= POLL_LOAD;
      else if (w_poll_dec) r_poll <= r_poll - 1'b1;
      r_pend <= (r_pend | thr_load) & ~w_pend_take;
    end
  end

  // Threshold shadows and sticky timeout error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_thigh <= DEF_THIGH;
      r_tlow  <= DEF_TLOW;
      r_tcrit <= DEF_TCRIT;
      r_thyst <= DEF_THYST;
      r_err   <= 1'b0;
    end else begin
      if (thr_load) begin
        r_thigh <= thr_high;
        r_tlow  <= thr_low;
        r_tcrit <= thr_crit;
        r_thyst <= thr_hyst;
      end
      if (thr_load)       r_err <= 1'b0;
      else if (w_err_set) r_err <= 1'b1;
    end
  end

  // Registered core strobes; target and value hold until the next write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_stb <= 1'b0;
      r_rd_stb <= 1'b0;
      r_tgt    <= '0;
      r_wval   <= '0;
    end else begin
      r_wr_stb <= w_wr_stb;
      r_rd_stb <= w_rd_stb;
      if (w_wr_stb) begin
        r_tgt  <= w_tgt;
        r_wval <= w_wval;
      end
    end
  end

  // Latch every valid reading, in any state, with signed alarm compares.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_temp      <= '0;
      r_tvalid    <= 1'b0;
      r_over_high <= 1'b0;
      r_under_low <= 1'b0;
      r_over_crit <= 1'b0;
    end else begin
      r_tvalid <= valid_o;
      if (valid_o) begin
        r_temp      <= temperature_o;
        r_over_high <= $signed(temperature_o) >= $signed(r_thigh);
        r_under_low <= $signed(temperature_o) <  $signed(r_tlow);
        r_over_crit <= $signed(temperature_o) >= $signed(r_tcrit);
      end
    end
  end

`ifdef TMP2_MINMAX_EN
  logic [15:0] r_min, r_max;

  // Min/max tracking; the sentinels make the first reading set both.
  always_ff @(posedge clk) begin
    if (rst || minmax_clr) begin
      r_min <= 16'h7FFF;
      r_max <= 16'h8000;
    end else if (valid_o) begin
      if ($signed(temperature_o) < $signed(r_min)) r_min <= temperature_o;
      if ($signed(temperature_o) > $signed(r_max)) r_max <= temperature_o;
    end
  end

  assign temp_min = r_min;
  assign temp_max = r_max;
`endif

  assign update            = r_rd_stb;
  assign write_temperature = r_wr_stb;
  assign write_temp_target = r_tgt;
  assign temperature_i     = r_wval;
  assign temp              = r_temp;
  assign temp_valid        = r_tvalid;
  assign over_high         = r_over_high;
  assign under_low         = r_under_low;
  assign over_crit         = r_over_crit;
  assign err_timeout       = r_err;

endmodule
